// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared width and FSM state encoding for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_cond_neg.sv
// ============================================================================
// Module      : div_cond_neg
// Description : Combinational conditional two's-complement negate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_cond_neg
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = neg_i ? ('0 - data_i) : data_i;

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle radix-2 restoring divider (DIV/DIVU) with annul.
//               Optional `DIV_ZERO_FLAG_EN adds the div_by_zero_o output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic               div_by_zero_o,
`endif
  output logic               ready_o
);

  localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               qneg_q, rneg_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
  logic [WIDTH:0]     w_shift, w_diff;
  logic               w_zero, w_accept, w_leave;

  assign w_zero   = (opdata2_i == '0);
  assign w_accept = (state_q == FREE) && start_i && !annul_i;
  assign w_leave  = annul_i || !start_i;

  div_cond_neg #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i (signed_div_i && opdata1_i[WIDTH-1]), .data_i (opdata1_i), .data_o (w_abs_a));
  div_cond_neg #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i (signed_div_i && opdata2_i[WIDTH-1]), .data_i (opdata2_i), .data_o (w_abs_b));
  div_cond_neg #(.WIDTH(WIDTH)) u_fix_q (
    .neg_i (qneg_q), .data_i (quo_q), .data_o (w_quo_fix));
  div_cond_neg #(.WIDTH(WIDTH)) u_fix_r (
    .neg_i (rneg_q), .data_i (rem_q), .data_o (w_rem_fix));

  // Partial remainder is always below 2*divisor, so bit WIDTH of the
  // difference is a reliable borrow (restore) indicator.
  assign w_shift = {rem_q, quo_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FREE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:    if (start_i && !annul_i) state_d = w_zero ? BYZERO : ON;
      BYZERO:  state_d = END;
      ON:      if (annul_i) state_d = FREE;
               else if (cnt_q == LAST_STEP) state_d = END;
      END:     if (w_leave) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  logic zero_q, dz_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      zero_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      if (w_accept) zero_q <= w_zero;
      if (state_q == END) dz_q <= zero_q && !w_leave;
      else                dz_q <= 1'b0;
    end
  end

  assign div_by_zero_o = dz_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          ready_q <= 1'b0;
          if (w_accept) begin
            // A zero divisor clears the datapath so END yields a zero result.
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= w_zero ? '0 : w_abs_a;
            dvs_q  <= w_abs_b;
            qneg_q <= !w_zero && signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rneg_q <= !w_zero && signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        ON: begin
          if (!annul_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!w_diff[WIDTH]) begin
              rem_q <= w_diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= w_shift[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        END: begin
          result_q <= {w_rem_fix, w_quo_fix};
          ready_q  <= !w_leave;
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

`default_nettype wire
